// File: rtl/ldst_mem_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ldst_mem_arb
//
// Arbitrates two requesters onto the single data-memory port and sequences
// one req/ack transaction at a time.
//   Port 0 : core load/store unit (address already resolved by execute).
//   Port 1 : secondary master (debug / loader path).
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   pN_req_i                     request, held with payload until pN_gnt_o
//   pN_addr_i/write_i/data_i     access address, 1 = store, store data
//   pN_gnt_o                     one-cycle grant (first BUSY cycle)
//   pN_done_o                    one-cycle completion (RESP cycle)
//   pN_rdata_o                   last load result of that port (held)
//   mem_req_o                    memory request, high for the whole BUSY phase
//   mem_addr_o/write_o/wdata_o   latched payload of the granted port
//   mem_ack_i, mem_rdata_i       memory completion and load data
//   busy_o                       transaction in flight (not IDLE)
//   err_o                        timeout flag, pulses together with done
//
// Optional feature (macro LDST_ARB_TIMEOUT_EN):
//   When defined, a BUSY phase lasting TIMEOUT cycles without an ack is
//   terminated with done + err; a load then returns 0 and a store is dropped.
//   When undefined, BUSY waits for the ack indefinitely and err_o is 0.
//
// Every output is a register or a decode of registered state; no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module ldst_mem_arb #(
    parameter int W_OPR   = 32,
    parameter int ADDR    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             p0_req_i,
    input  logic [ADDR-1:0]  p0_addr_i,
    input  logic             p0_write_i,
    input  logic [W_OPR-1:0] p0_data_i,
    output logic             p0_gnt_o,
    output logic             p0_done_o,
    output logic [W_OPR-1:0] p0_rdata_o,

    input  logic             p1_req_i,
    input  logic [ADDR-1:0]  p1_addr_i,
    input  logic             p1_write_i,
    input  logic [W_OPR-1:0] p1_data_i,
    output logic             p1_gnt_o,
    output logic             p1_done_o,
    output logic [W_OPR-1:0] p1_rdata_o,

    output logic             mem_req_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic             mem_write_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [W_OPR-1:0] mem_rdata_i,

    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // 0 = port 0, 1 = port 1
    logic             last_q;             // port granted most recently
    logic             first_q;            // high in the first BUSY cycle only
    logic             start;              // IDLE -> BUSY this cycle
    logic             ack_ok;             // accepted ack this cycle

    logic [ADDR-1:0]  addr_q;
    logic             write_q;
    logic [W_OPR-1:0] wdata_q;
    logic [W_OPR-1:0] rdata0_q, rdata1_q;

    // Payload of the port that is about to be granted.
    logic [ADDR-1:0]  sel_addr;
    logic             sel_write;
    logic [W_OPR-1:0] sel_data;

`ifdef LDST_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo;
    logic             err_q;
`else
    // TIMEOUT only matters when the timeout logic is built in.
    logic             unused_timeout;
    assign unused_timeout = (TIMEOUT >= 1);
`endif

    // -------------------------------------------------------------------------
    // Next state, arbitration and transaction events
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        start   = 1'b0;
        ack_ok  = 1'b0;
`ifdef LDST_ARB_TIMEOUT_EN
        tmo     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    start   = 1'b1;
                    state_d = BUSY;
                    // Tie goes to the port not granted last; otherwise the
                    // sole requester wins.
                    owner_d = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    // An ack on the final allowed cycle still wins over the
                    // timeout.
                    ack_ok  = 1'b1;
                    state_d = RESP;
                end
`ifdef LDST_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_addr  = p0_addr_i;
        sel_write = p0_write_i;
        sel_data  = p0_data_i;
        if (owner_d) begin
            sel_addr  = p1_addr_i;
            sel_write = p1_write_i;
            sel_data  = p1_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // so port 0 wins the first tie
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            first_q <= start;
            if (state_q == RESP) begin
                last_q <= owner_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Latched request payload and per-port load results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (start) begin
                addr_q  <= sel_addr;
                write_q <= sel_write;
                wdata_q <= sel_data;
            end
            if (ack_ok && !write_q) begin
                if (owner_q) begin
                    rdata1_q <= mem_rdata_i;
                end else begin
                    rdata0_q <= mem_rdata_i;
                end
            end
`ifdef LDST_ARB_TIMEOUT_EN
            // A timed-out load returns zero; a timed-out store is dropped.
            if (tmo && !write_q) begin
                if (owner_q) begin
                    rdata1_q <= '0;
                end else begin
                    rdata0_q <= '0;
                end
            end
`endif
        end
    end

`ifdef LDST_ARB_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // BUSY cycle counter and timeout flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if ((state_q == BUSY) && !mem_ack_i && !tmo) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Sampled on the BUSY -> RESP edge and only read during RESP.
            err_q <= tmo;
        end
    end

    assign err_o = (state_q == RESP) && err_q;
`else
    assign err_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    assign mem_req_o   = (state_q == BUSY);
    assign mem_addr_o  = addr_q;
    assign mem_write_o = write_q;
    assign mem_wdata_o = wdata_q;

    assign p0_gnt_o    = (state_q == BUSY) && first_q && !owner_q;
    assign p1_gnt_o    = (state_q == BUSY) && first_q &&  owner_q;
    assign p0_done_o   = (state_q == RESP) && !owner_q;
    assign p1_done_o   = (state_q == RESP) &&  owner_q;

    assign p0_rdata_o  = rdata0_q;
    assign p1_rdata_o  = rdata1_q;

    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ldst_mem_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ldst_mem_arb
//
// Directed scenarios followed by randomized traffic. The reference model is
// transaction level: it keeps the round-robin pointer, the pending requests
// and the two ports' load results, and derives the expected winner, cycle
// timing and results from the arbitration and handshake rules.
// -----------------------------------------------------------------------------
module tb_ldst_mem_arb;

    localparam int W   = 32;
    localparam int A   = 16;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         p0_req, p1_req, p0_write, p1_write;
    logic [A-1:0] p0_addr, p1_addr;
    logic [W-1:0] p0_data, p1_data;
    logic         p0_gnt, p1_gnt, p0_done, p1_done;
    logic [W-1:0] p0_rdata, p1_rdata;
    logic         mem_req, mem_write, mem_ack, busy, err;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata, mem_rdata;

    // Requester side and model state
    logic         pend   [2];
    logic [A-1:0] p_addr [2];
    logic         p_wr   [2];
    logic [W-1:0] p_data [2];
    logic [W-1:0] m_rdata[2];
    int           m_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign p0_req   = pend[0];
    assign p0_addr  = p_addr[0];
    assign p0_write = p_wr[0];
    assign p0_data  = p_data[0];
    assign p1_req   = pend[1];
    assign p1_addr  = p_addr[1];
    assign p1_write = p_wr[1];
    assign p1_data  = p_data[1];

    ldst_mem_arb #(
        .W_OPR   (W),
        .ADDR    (A),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p0_req_i    (p0_req),
        .p0_addr_i   (p0_addr),
        .p0_write_i  (p0_write),
        .p0_data_i   (p0_data),
        .p0_gnt_o    (p0_gnt),
        .p0_done_o   (p0_done),
        .p0_rdata_o  (p0_rdata),
        .p1_req_i    (p1_req),
        .p1_addr_i   (p1_addr),
        .p1_write_i  (p1_write),
        .p1_data_i   (p1_data),
        .p1_gnt_o    (p1_gnt),
        .p1_done_o   (p1_done),
        .p1_rdata_o  (p1_rdata),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_write_o (mem_write),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int p, input logic [A-1:0] a, input logic wr, input logic [W-1:0] d);
        pend[p]   = 1'b1;
        p_addr[p] = a;
        p_wr[p]   = wr;
        p_data[p] = d;
    endtask

    task automatic raise_rand(input int p);
        raise(p, A'($urandom), 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic chk_rdata();
        chk("p0_rdata", p0_rdata, m_rdata[0]);
        chk("p1_rdata", p1_rdata, m_rdata[1]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_p0_gnt"},  p0_gnt,  0);
        chk({tag, "_p1_gnt"},  p1_gnt,  0);
        chk({tag, "_p0_done"}, p0_done, 0);
        chk({tag, "_p1_done"}, p1_done, 0);
        chk({tag, "_err"},     err,     0);
    endtask

    // One complete transaction, starting in an IDLE cycle with at least one
    // request pending. d = BUSY cycle (1-based) in which memory acks.
    // Returns the port the model expected to win.
    task automatic run_txn(input int d, input logic [W-1:0] rd, input bit traffic, output int own);
        logic [A-1:0] a;
        logic         w;
        logic [W-1:0] wd;
        bit           tmo;
        int           nbusy;
        int           oth;
        own   = (pend[0] && pend[1]) ? ((m_last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
        oth   = 1 - own;
        a     = p_addr[own];
        w     = p_wr[own];
        wd    = p_data[own];
        tmo   = 1'b0;
        nbusy = d;
`ifdef LDST_ARB_TIMEOUT_EN
        if (d > TMO) begin
            tmo   = 1'b1;
            nbusy = TMO;
        end
`endif
        step();
        for (int i = 1; i <= nbusy; i++) begin
            chk("busy",      busy,      1);
            chk("mem_req",   mem_req,   1);
            chk("mem_addr",  mem_addr,  a);
            chk("mem_write", mem_write, w);
            chk("mem_wdata", mem_wdata, wd);
            chk("p0_gnt",    p0_gnt,    (i == 1) && (own == 0));
            chk("p1_gnt",    p1_gnt,    (i == 1) && (own == 1));
            chk("p0_done",   p0_done,   0);
            chk("p1_done",   p1_done,   0);
            chk("err",       err,       0);
            chk_rdata();
            if (i == 1) begin
                pend[own] = 1'b0;
                // A request raised while busy must wait for IDLE.
                if (traffic && !pend[oth] && ($urandom_range(0, 2) == 0)) begin
                    raise_rand(oth);
                end
            end
            if ((i == nbusy) && !tmo) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            step();
        end
        // RESP cycle
        if (!w) begin
            m_rdata[own] = tmo ? '0 : rd;
        end
        mem_ack   = traffic ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        chk("resp_p0_done", p0_done, own == 0);
        chk("resp_p1_done", p1_done, own == 1);
        chk("resp_err",     err,     tmo);
        chk("resp_mem_req", mem_req, 0);
        chk("resp_busy",    busy,    1);
        chk("resp_p0_gnt",  p0_gnt,  0);
        chk("resp_p1_gnt",  p1_gnt,  0);
        chk_rdata();
        m_last = own;
        step();
        mem_ack = 1'b0;
        chk_quiet("idle");
        chk_rdata();
    endtask

    initial begin
        int own;
        int prev;
        int hold;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p]    = 1'b0;
            p_addr[p]  = '0;
            p_wr[p]    = 1'b0;
            p_data[p]  = '0;
            m_rdata[p] = '0;
        end
        m_last = 1;

        // Reset state
        #12;
        chk_quiet("rst");
        chk_rdata();
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        step();
        rst = 1'b0;
        chk_quiet("rel");

        // p0 load, acked in first BUSY cycle
        raise(0, 16'h0010, 1'b0, 32'h0);
        run_txn(1, 32'hDEADBEEF, 1'b0, own);
        chk("t1_owner",    own,      0);
        chk("t1_p0_rdata", p0_rdata, 32'hDEADBEEF);

        // p1 store, ack in 4th BUSY cycle; rdata must not change
        raise(1, 16'h0200, 1'b1, 32'h12345678);
        run_txn(4, 32'hA5A5A5A5, 1'b0, own);
        chk("t2_owner",    own,      1);
        chk("t2_p1_rdata", p1_rdata, 32'h0);

        // Both request continuously: grants alternate
        raise_rand(0);
        raise_rand(1);
        prev = m_last;
        for (int n = 0; n < 6; n++) begin
            run_txn($urandom_range(1, 3), $urandom, 1'b0, own);
            chk("alt_owner", own, 1 - prev);
            prev = own;
            raise_rand(own);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        step();

        // Reset in the middle of BUSY: no done, fresh grant afterwards
        raise(0, 16'h0044, 1'b0, 32'h0);
        step();
        chk("rb_p0_gnt",  p0_gnt,  1);
        chk("rb_mem_req", mem_req, 1);
`ifdef LDST_ARB_TIMEOUT_EN
        hold = TMO - 2;
`else
        hold = 20;
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_busy",    busy,    1);
            chk("hold_mem_req", mem_req, 1);
            chk("hold_err",     err,     0);
            chk("hold_p0_gnt",  p0_gnt,  0);
            chk("hold_p0_done", p0_done, 0);
        end
        #3;
        rst = 1'b1;
        #1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_last     = 1;
        chk_quiet("arst");
        chk_rdata();
        step();
        chk_quiet("arst2");
        rst = 1'b0;
        // First tie after reset goes to port 0
        raise(1, 16'h0300, 1'b0, 32'h0);
        run_txn(2, 32'hCAFEF00D, 1'b0, own);
        chk("rr_owner",    own,      0);
        chk("rr_p0_rdata", p0_rdata, 32'hCAFEF00D);
        run_txn(1, 32'h0BADF00D, 1'b0, own);
        chk("rr2_owner",   own,      1);

`ifdef LDST_ARB_TIMEOUT_EN
        // Load never acked: done + err after TMO BUSY cycles, rdata = 0
        raise(0, 16'h0010, 1'b0, 32'h0);
        run_txn(TMO + 20, 32'h0, 1'b0, own);
        chk("tmo_p0_rdata", p0_rdata, 32'h0);
`endif

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    raise_rand(p);
                end
            end
            if (!pend[0] && !pend[1]) begin
                raise_rand(int'($urandom_range(0, 1)));
            end
`ifdef LDST_ARB_TIMEOUT_EN
            run_txn($urandom_range(1, TMO + 2), $urandom, 1'b1, own);
`else
            run_txn($urandom_range(1, 5), $urandom, 1'b1, own);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldst_mem_arb.md
# ldst_mem_arb

Two-requester arbiter and sequencer for the single data-memory port.
- Port 0 is the core load/store unit. It presents an address already resolved from base register plus optional immediate, a write flag, and store data from the second operand.
- Port 1 is a secondary master such as the debug or loader path.
- The block grants one requester at a time round-robin, drives a req/ack memory handshake and returns load data with a done pulse.
- It sits between the execute stage and the data-memory interface.

## Interface
Parameters:
- W_OPR, 32, data/operand width
- ADDR, 16, memory address width
- TIMEOUT, 15, maximum BUSY cycles awaiting mem_ack_i (used only with timeout enabled; must be ≥1)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- p0_req_i / p1_req_i  in  1  request; held with payload stable until matching gnt
- p0_addr_i / p1_addr_i  in  ADDR  access address
- p0_write_i / p1_write_i  in  1  1 = store, 0 = load
- p0_data_i / p1_data_i  in  W_OPR  store data
- p0_gnt_o / p1_gnt_o  out  1  one-cycle grant pulse
- p0_done_o / p1_done_o  out  1  one-cycle completion pulse
- p0_rdata_o / p1_rdata_o  out  W_OPR  load result, held until the port's next completed load
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR  latched address
- mem_write_o  out  1  latched write flag
- mem_wdata_o  out  W_OPR  latched store data
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  W_OPR  load data, valid with mem_ack_i
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  timeout flag, pulses with done

## Operation
FSM has three states: IDLE, BUSY and RESP.

IDLE:
- If any request is pending, select the owner.
- A sole requester wins.
- If both request, the port not granted last wins. The last-grant pointer resets so port 0 wins the first tie.
- On the clock edge, latch owner, address, write flag and data, clear the timeout counter and go to BUSY.
- With no request pending, stay in IDLE.

BUSY:
- mem_req_o = 1; mem_addr_o, mem_write_o and mem_wdata_o come from the latched values.
- Owner's gnt_o = 1 in the first BUSY cycle only.
- On mem_ack_i = 1:
  - For a load, capture mem_rdata_i into the owner's rdata register.
  - For a store, leave rdata unchanged.
  - Go to RESP.
- Otherwise stay in BUSY and increment the counter.

RESP:
- Owner's done_o = 1 and mem_req_o = 0.
- Update the last-grant pointer to the owner.
- Go to IDLE.

General rules:
- mem_ack_i is ignored in IDLE and RESP.
- The non-owner's outputs stay 0, and its rdata is untouched.
- Requests arriving during BUSY/RESP wait; the requester keeps req_i high.
- Arbitration occurs only in IDLE.
- Reset at any time (asynchronous):
  - state = IDLE, all outputs 0, both rdata registers 0, pointer = port 1 (so port 0 wins the first tie), counter 0.
  - mem_req_o drops immediately.
  - The in-flight transaction is discarded with no done.

## Timing
Cycle-level sequence for a request seen in IDLE at cycle n:
- Cycle n+1: gnt and mem_req_o.
- Ack in cycle n+k (k ≥ 1): done and rdata valid in cycle n+k+1.
- Cycle n+k+2: IDLE; next grant no earlier than n+k+3.

Throughput and sampling:
- Minimum transaction is 3 cycles edge-to-edge.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Configuration
Macro LDST_ARB_TIMEOUT_EN.

Defined:
- The counter has width $clog2(TIMEOUT+1).
- If it reaches TIMEOUT in BUSY without ack, go to RESP with done_o = 1 and err_o = 1.
- A load's rdata is set to 0; a store is dropped.
- An ack in the same cycle as the counter reaching TIMEOUT is accepted normally with err_o = 0.

Undefined:
- No counter logic; BUSY waits indefinitely.
- err_o is tied 0.

## Test plan
- Reset, then p0 load addr 0x0010; memory acks the first BUSY cycle with 0xDEADBEEF -> p0_gnt_o at cycle 1, p0_done_o at cycle 2, p0_rdata_o = 0xDEADBEEF, p1 outputs remain 0.
- p1 store addr 0x0200, data 0x12345678; ack delayed 4 cycles -> mem_req_o high 4 cycles with mem_write_o = 1 and mem_wdata_o = 0x12345678; p1_done_o one cycle after ack; p1_rdata_o unchanged.
- Both ports request continuously after reset -> grants alternate p0, p1, p0, p1; each transaction completes before the next grant.
- Assert rst_i mid-BUSY -> mem_req_o drops immediately with no done pulse; after release, the still-pending p0 request is granted fresh.
- With LDST_ARB_TIMEOUT_EN and TIMEOUT = 3, p0 load never acked -> done and err_o pulse together after 3 BUSY cycles, p0_rdata_o = 0. Without the macro, busy_o stays high and err_o stays 0.
